// File: rtl/seven_segment_reader.sv
// Receiver for a 7-segment display bus: synchronizes and debounces the segment/dp lines,
// decodes accepted glyphs to hex digits, hands them out over valid/ack and checks the count sequence.
module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter bit CHECK_SEQ     = 1'b1
) (
    input  logic             input_clock1_1,
    input  logic             input_push_button1_2,
    input  logic [6:0]       input_segments_3,
    input  logic             input_dp_4,
    input  logic             input_ack_5,
    output logic [3:0]       output_digit_6,
    output logic             output_digit_valid_7,
    output logic             output_dp_8,
    output logic             output_blank_9,
    output logic             output_invalid_pulse_10,
    output logic             output_seq_error_11,
    output logic             output_overrun_12,
    output logic [CNT_W-1:0] output_count_13
);

    localparam int              SC_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [7:0]      s1, s2, s3, acc;
    logic [SC_W-1:0] stab_cnt;
    logic            accept;
    logic            prev_valid;
    logic [4:0]      dec;
    logic            seg_new;

    // Returns {legal, digit}; illegal codes (including blank) return 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        dec       = decode(s2[6:0]);
        seg_new   = (s2[6:0] != acc[6:0]);
        case (state)
            IDLE:    if (s2 != s3) state_nxt = SETTLE;
            SETTLE:  if (s2 == s3 && stab_cnt == SC_MAX) begin
                         accept    = 1'b1;
                         state_nxt = LOCKED;
                     end
            LOCKED:  if (s2 != acc) state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge input_clock1_1) begin
        if (!input_push_button1_2) begin
            state                   <= IDLE;
            s1                      <= '0;
            s2                      <= '0;
            s3                      <= '0;
            acc                     <= '0;
            stab_cnt                <= '0;
            prev_valid              <= 1'b0;
            output_digit_6          <= '0;
            output_digit_valid_7    <= 1'b0;
            output_dp_8             <= 1'b0;
            output_blank_9          <= 1'b0;
            output_invalid_pulse_10 <= 1'b0;
            output_seq_error_11     <= 1'b0;
            output_overrun_12       <= 1'b0;
            output_count_13         <= '0;
        end else begin
            s1    <= {input_dp_4, input_segments_3};
            s2    <= s1;
            s3    <= s2;
            state <= state_nxt;

            if (s2 != s3)
                stab_cnt <= '0;
            else if (stab_cnt != SC_MAX)
                stab_cnt <= stab_cnt + 1'b1;

            output_invalid_pulse_10 <= 1'b0;
            if (output_digit_valid_7 && input_ack_5)
                output_digit_valid_7 <= 1'b0;

            // A new digit overrides the ack-driven clear above, so ack + update keeps valid high.
            if (accept) begin
                acc         <= s2;
                output_dp_8 <= s2[7];
                if (seg_new) begin
                    if (dec[4]) begin
                        output_digit_6       <= dec[3:0];
                        output_digit_valid_7 <= 1'b1;
                        output_blank_9       <= 1'b0;
                        prev_valid           <= 1'b1;
                        if (output_count_13 != '1)
                            output_count_13 <= output_count_13 + 1'b1;
                        if (output_digit_valid_7 && !input_ack_5)
                            output_overrun_12 <= 1'b1;
                        if (CHECK_SEQ && prev_valid && dec[3:0] != output_digit_6 + 4'd1)
                            output_seq_error_11 <= 1'b1;
                    end else if (s2[6:0] == '0) begin
                        output_blank_9 <= 1'b1;
                        prev_valid     <= 1'b0;
                    end else begin
                        output_invalid_pulse_10 <= 1'b1;
                        output_blank_9          <= 1'b0;
                        prev_valid              <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with STABLE_CYCLES=4, CNT_W=8, CHECK_SEQ=1.
module tb_seven_segment_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic [3:0] digit;
    logic       valid, dp_out, blank, inv, seq_err, ovr;
    logic [7:0] count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] digit;
    } vec_t;
    vec_t tbl[16];

    seven_segment_reader #(
        .STABLE_CYCLES(4),
        .CNT_W(8),
        .CHECK_SEQ(1'b1)
    ) dut (
        .input_clock1_1         (clk),
        .input_push_button1_2   (rst_n),
        .input_segments_3       (seg),
        .input_dp_4             (dp),
        .input_ack_5            (ack),
        .output_digit_6         (digit),
        .output_digit_valid_7   (valid),
        .output_dp_8            (dp_out),
        .output_blank_9         (blank),
        .output_invalid_pulse_10(inv),
        .output_seq_error_11    (seq_err),
        .output_overrun_12      (ovr),
        .output_count_13        (count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{7'h06, 4'h1}; tbl[1]  = '{7'h5B, 4'h2};
        tbl[2]  = '{7'h4F, 4'h3}; tbl[3]  = '{7'h66, 4'h4};
        tbl[4]  = '{7'h6D, 4'h5}; tbl[5]  = '{7'h7D, 4'h6};
        tbl[6]  = '{7'h07, 4'h7}; tbl[7]  = '{7'h7F, 4'h8};
        tbl[8]  = '{7'h6F, 4'h9}; tbl[9]  = '{7'h77, 4'hA};
        tbl[10] = '{7'h7C, 4'hB}; tbl[11] = '{7'h39, 4'hC};
        tbl[12] = '{7'h5E, 4'hD}; tbl[13] = '{7'h79, 4'hE};
        tbl[14] = '{7'h71, 4'hF}; tbl[15] = '{7'h3F, 4'h0};

        rst_n = 1'b0; seg = '0; dp = 1'b0; ack = 1'b0;
        tick(3);
        chk("reset_outs", {digit, valid, dp_out, blank, inv, seq_err, ovr, count}, 0);

        // First glyph: valid must appear exactly six edges after the first sampling edge.
        rst_n = 1'b1; seg = 7'h3F;
        tick(6);
        chk("latency_early", valid, 0);
        tick(1);
        chk("first_valid", valid, 1);
        chk("first_digit", digit, 0);
        chk("first_count", count, 1);
        tick(4);
        chk("hold_valid", valid, 1);
        chk("hold_count", count, 1);
        do_ack();
        chk("ack_clears", valid, 0);

        // Two-cycle glitch inside a held glyph must not produce a new digit.
        seg = 7'h06;
        tick(2);
        seg = 7'h3F;
        tick(10);
        chk("glitch_digit", digit, 0);
        chk("glitch_valid", valid, 0);
        chk("glitch_count", count, 1);

        for (int i = 0; i < 16; i++) begin
            seg = tbl[i].seg;
            tick(7);
            chk($sformatf("step%0d_digit", i), digit, tbl[i].digit);
            chk($sformatf("step%0d_valid", i), valid, 1);
            chk($sformatf("step%0d_count", i), count, 32'(i + 2));
            chk($sformatf("step%0d_seq", i), seq_err, 0);
            do_ack();
            chk($sformatf("step%0d_ack", i), valid, 0);
        end
        chk("wrap_count", count, 17);
        chk("wrap_ovr", ovr, 0);

        // Illegal glyph: one-cycle pulse, then 0->8 is not sequence-checked.
        seg = 7'h55;
        tick(7);
        chk("inv_pulse", inv, 1);
        chk("inv_digit", digit, 0);
        chk("inv_valid", valid, 0);
        tick(1);
        chk("inv_pulse_end", inv, 0);
        seg = 7'h7F;
        tick(7);
        chk("after_inv_digit", digit, 8);
        chk("after_inv_seq", seq_err, 0);
        chk("after_inv_count", count, 18);
        do_ack();

        seg = 7'h00;
        tick(7);
        chk("blank_flag", blank, 1);
        chk("blank_digit", digit, 8);
        chk("blank_valid", valid, 0);

        seg = 7'h06;
        tick(7);
        chk("post_blank_digit", digit, 1);
        chk("post_blank_blank", blank, 0);
        chk("post_blank_seq", seq_err, 0);
        chk("post_blank_ovr", ovr, 0);

        seg = 7'h4F;
        tick(7);
        chk("skip_digit", digit, 3);
        chk("skip_seq", seq_err, 1);
        chk("skip_ovr", ovr, 1);
        chk("skip_valid", valid, 1);
        chk("skip_count", count, 20);

        // dp-only change: dp follows, no new digit.
        dp = 1'b1;
        tick(7);
        chk("dp_only_dp", dp_out, 1);
        chk("dp_only_count", count, 20);
        chk("dp_only_digit", digit, 3);
        chk("sticky_seq", seq_err, 1);
        chk("sticky_ovr", ovr, 1);

        // Reset mid-settle while a digit is still pending.
        seg = 7'h5B; dp = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("midreset_outs", {digit, valid, dp_out, blank, inv, seq_err, ovr, count}, 0);
        rst_n = 1'b1;
        tick(7);
        chk("post_reset_digit", digit, 2);
        chk("post_reset_valid", valid, 1);
        chk("post_reset_seq", seq_err, 0);
        chk("post_reset_ovr", ovr, 0);
        chk("post_reset_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
